// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory handshake, decode-side control
// and the head-of-queue outputs.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] dataout;
  logic [31:0] pc_out;
  logic        valid;

  modport master (
    output imem_req, imem_addr, dataout, pc_out, valid,
    input  imem_ack, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, dataout, pc_out, valid,
    output imem_ack, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory request, 2-entry
// {instr, pc} queue, redirect flush with in-flight response discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t      state, state_nx;
  logic [1:0]  count, count_nx;
  logic [1:0]  occ;
  logic        pop, push;
  logic        req_q, req_nx;
  logic [31:0] addr_q, addr_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic [31:0] head_instr, head_instr_nx, head_pc, head_pc_nx;
  logic [31:0] tail_instr, tail_instr_nx, tail_pc, tail_pc_nx;

  always_comb begin
    pop  = (count != 2'd0) && !bus.stall && !bus.redirect;
    push = (state == WAIT) && bus.imem_ack && !bus.redirect;
    occ  = count - {1'b0, pop};

    state_nx      = state;
    addr_nx       = addr_q;
    fetch_pc_nx   = fetch_pc;
    count_nx      = occ + {1'b0, push};
    head_instr_nx = head_instr;
    head_pc_nx    = head_pc;
    tail_instr_nx = tail_instr;
    tail_pc_nx    = tail_pc;

    if (pop) begin
      head_instr_nx = tail_instr;
      head_pc_nx    = tail_pc;
    end
    // The pushed entry lands behind whatever survives this cycle's pop.
    if (push) begin
      if (occ == 2'd0) begin
        head_instr_nx = bus.imem_rdata;
        head_pc_nx    = addr_q;
      end else begin
        tail_instr_nx = bus.imem_rdata;
        tail_pc_nx    = addr_q;
      end
    end

    case (state)
      IDLE: begin
        if (!bus.redirect && occ < 2'd2) begin
          state_nx = WAIT;
          addr_nx  = fetch_pc;
        end
      end
      WAIT: begin
        if (bus.redirect) begin
          state_nx = bus.imem_ack ? IDLE : DROP;
        end else if (bus.imem_ack) begin
          fetch_pc_nx = addr_q + 32'd4;
          if (occ == 2'd0) addr_nx = addr_q + 32'd4;
          else             state_nx = IDLE;
        end
      end
      DROP: begin
        if (bus.imem_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (bus.redirect) begin
      count_nx    = 2'd0;
      fetch_pc_nx = bus.redirect_pc & ~32'h3;
    end

    req_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= 2'd0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      fetch_pc   <= RESET_PC & ~32'h3;
      head_instr <= '0;
      head_pc    <= '0;
      tail_instr <= '0;
      tail_pc    <= '0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      req_q      <= req_nx;
      addr_q     <= addr_nx;
      fetch_pc   <= fetch_pc_nx;
      head_instr <= head_instr_nx;
      head_pc    <= head_pc_nx;
      tail_instr <= tail_instr_nx;
      tail_pc    <= tail_pc_nx;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.valid     = (count != 2'd0);
  assign bus.dataout   = (count != 2'd0) ? head_instr : '0;
  assign bus.pc_out    = (count != 2'd0) ? head_pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, async reset,
// and address wrap on a second instance with a high RESET_PC.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_en = 1'b1;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  // Auto-responder acks in the first cycle a request is visible; data = addr + 1000_0000.
  assign bus.imem_ack    = mem_en ? bus.imem_req : man_ack;
  assign bus.imem_rdata  = mem_en ? (bus.imem_addr + 32'h1000_0000) : man_rdata;
  assign bus.stall       = stall;
  assign bus.redirect    = redirect;
  assign bus.redirect_pc = redirect_pc;

  assign bus2.imem_ack    = bus2.imem_req;
  assign bus2.imem_rdata  = bus2.imem_addr + 32'h1000_0000;
  assign bus2.stall       = 1'b0;
  assign bus2.redirect    = 1'b0;
  assign bus2.redirect_pc = '0;

  fetch_unit u_dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clock (clk),
    .reset (rst2_n),
    .bus   (bus2)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr} !== 33'd0) begin
      n_bad++;
      $display("FAIL reset_req_addr: got %h expected %h", {bus.imem_req, bus.imem_addr}, 33'd0);
    end
    n_cmp++;
    if ({bus.valid, bus.pc_out, bus.dataout} !== 65'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected %h", {bus.valid, bus.pc_out, bus.dataout}, 65'd0);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr, bus.valid} !== {1'b1, 32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL seq_first_req: got %h expected %h",
               {bus.imem_req, bus.imem_addr, bus.valid}, {1'b1, 32'd0, 1'b0});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_pc = 32'd4 * i;
      n_cmp++;
      if ({bus.valid, bus.pc_out, bus.dataout} !== {1'b1, exp_pc, exp_pc + 32'h1000_0000}) begin
        n_bad++;
        $display("FAIL seq_head[%0d]: got %h expected %h", i,
                 {bus.valid, bus.pc_out, bus.dataout}, {1'b1, exp_pc, exp_pc + 32'h1000_0000});
      end
      n_cmp++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, exp_pc + 32'd4}) begin
        n_bad++;
        $display("FAIL seq_addr[%0d]: got %h expected %h", i,
                 {bus.imem_req, bus.imem_addr}, {1'b1, exp_pc + 32'd4});
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({bus.imem_req, bus.valid, bus.pc_out, bus.dataout} !== {1'b0, 1'b1, 32'd20, 32'h1000_0014}) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", i,
                 {bus.imem_req, bus.valid, bus.pc_out, bus.dataout}, {1'b0, 1'b1, 32'd20, 32'h1000_0014});
      end
    end
    stall = 1'b0;
    tick();
    n_cmp++;
    if ({bus.valid, bus.pc_out, bus.imem_req, bus.imem_addr} !== {1'b1, 32'd24, 1'b1, 32'd28}) begin
      n_bad++;
      $display("FAIL stall_drain0: got %h expected %h",
               {bus.valid, bus.pc_out, bus.imem_req, bus.imem_addr}, {1'b1, 32'd24, 1'b1, 32'd28});
    end
    tick();
    n_cmp++;
    if ({bus.valid, bus.pc_out, bus.dataout, bus.imem_addr} !== {1'b1, 32'd28, 32'h1000_001C, 32'd32}) begin
      n_bad++;
      $display("FAIL stall_drain1: got %h expected %h",
               {bus.valid, bus.pc_out, bus.dataout, bus.imem_addr}, {1'b1, 32'd28, 32'h1000_001C, 32'd32});
    end
  endtask

  task automatic test_redirect_wait();
    mem_en      = 1'b0;
    man_ack     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1003;
    tick();
    n_cmp++;
    if ({bus.valid, bus.pc_out, bus.dataout} !== 65'd0) begin
      n_bad++;
      $display("FAIL rdw_flush: got %h expected %h", {bus.valid, bus.pc_out, bus.dataout}, 65'd0);
    end
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'd32}) begin
      n_bad++;
      $display("FAIL rdw_held_req: got %h expected %h", {bus.imem_req, bus.imem_addr}, {1'b1, 32'd32});
    end
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({bus.imem_req, bus.imem_addr, bus.valid} !== {1'b1, 32'd32, 1'b0}) begin
        n_bad++;
        $display("FAIL rdw_drop[%0d]: got %h expected %h", i,
                 {bus.imem_req, bus.imem_addr, bus.valid}, {1'b1, 32'd32, 1'b0});
      end
    end
    man_ack   = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    tick();
    n_cmp++;
    if ({bus.imem_req, bus.valid, bus.dataout} !== {1'b0, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL rdw_discard: got %h expected %h",
               {bus.imem_req, bus.valid, bus.dataout}, {1'b0, 1'b0, 32'd0});
    end
    // Ack while idle must not push anything.
    man_rdata = 32'hFFFF_0000;
    tick();
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr, bus.valid} !== {1'b1, 32'h0000_1000, 1'b0}) begin
      n_bad++;
      $display("FAIL rdw_target: got %h expected %h",
               {bus.imem_req, bus.imem_addr, bus.valid}, {1'b1, 32'h0000_1000, 1'b0});
    end
    man_rdata = 32'h1234_5678;
    tick();
    n_cmp++;
    if ({bus.valid, bus.pc_out, bus.dataout, bus.imem_addr} !== {1'b1, 32'h1000, 32'h1234_5678, 32'h1004}) begin
      n_bad++;
      $display("FAIL rdw_deliver: got %h expected %h",
               {bus.valid, bus.pc_out, bus.dataout, bus.imem_addr}, {1'b1, 32'h1000, 32'h1234_5678, 32'h1004});
    end
    man_ack = 1'b0;
  endtask

  task automatic test_redirect_ack();
    man_ack     = 1'b1;
    man_rdata   = 32'hBAD0_0000;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2000;
    tick();
    n_cmp++;
    if ({bus.imem_req, bus.valid, bus.pc_out, bus.dataout} !== 66'd0) begin
      n_bad++;
      $display("FAIL rda_flush: got %h expected %h", {bus.imem_req, bus.valid, bus.pc_out, bus.dataout}, 66'd0);
    end
    man_ack  = 1'b0;
    redirect = 1'b0;
    tick();
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr, bus.valid} !== {1'b1, 32'h0000_2000, 1'b0}) begin
      n_bad++;
      $display("FAIL rda_target: got %h expected %h",
               {bus.imem_req, bus.imem_addr, bus.valid}, {1'b1, 32'h0000_2000, 1'b0});
    end
    man_ack   = 1'b1;
    man_rdata = 32'h5555_AAAA;
    tick();
    n_cmp++;
    if ({bus.valid, bus.pc_out, bus.dataout, bus.imem_addr} !== {1'b1, 32'h2000, 32'h5555_AAAA, 32'h2004}) begin
      n_bad++;
      $display("FAIL rda_deliver: got %h expected %h",
               {bus.valid, bus.pc_out, bus.dataout, bus.imem_addr}, {1'b1, 32'h2000, 32'h5555_AAAA, 32'h2004});
    end
    man_ack = 1'b0;
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.imem_req, bus.valid, bus.pc_out, bus.dataout, bus.imem_addr} !== 98'd0) begin
      n_bad++;
      $display("FAIL arst_immediate: got %h expected %h",
               {bus.imem_req, bus.valid, bus.pc_out, bus.dataout, bus.imem_addr}, 98'd0);
    end
    @(negedge clk);
    mem_en = 1'b1;
    rst_n  = 1'b1;
    tick();
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr, bus.valid} !== {1'b1, 32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL arst_first_req: got %h expected %h",
               {bus.imem_req, bus.imem_addr, bus.valid}, {1'b1, 32'd0, 1'b0});
    end
    tick();
    n_cmp++;
    if ({bus.valid, bus.pc_out, bus.dataout} !== {1'b1, 32'd0, 32'h1000_0000}) begin
      n_bad++;
      $display("FAIL arst_first_data: got %h expected %h",
               {bus.valid, bus.pc_out, bus.dataout}, {1'b1, 32'd0, 32'h1000_0000});
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    rst2_n = 1'b1;
    tick();
    n_cmp++;
    if ({bus2.imem_req, bus2.imem_addr} !== {1'b1, 32'hFFFF_FFF8}) begin
      n_bad++;
      $display("FAIL wrap_first_req: got %h expected %h", {bus2.imem_req, bus2.imem_addr}, {1'b1, 32'hFFFF_FFF8});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({bus2.valid, bus2.pc_out, bus2.dataout} !== {1'b1, exp_pc[i], exp_pc[i] + 32'h1000_0000}) begin
        n_bad++;
        $display("FAIL wrap_pc[%0d]: got %h expected %h", i,
                 {bus2.valid, bus2.pc_out, bus2.dataout}, {1'b1, exp_pc[i], exp_pc[i] + 32'h1000_0000});
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
